// File: rtl/instr_prefetch.sv
// Instruction prefetch buffer: issues sequential word fetches on a
// request/grant bus, collects in-order responses into a DEPTH-entry FIFO,
// and hands them to decode with a valid/ready handshake.
//
// Handshake: an instruction transfers on any rising edge where instr_valid
// and instr_ready are both high; a bus request transfers on any rising edge
// where mem_req and mem_gnt are both high, and mem_req/mem_addr are held
// until that happens.
//
// Optional feature: define INSTR_PREFETCH_FLUSH_CNT_EN to add the flush_cnt
// output, a saturating count of redirect cycles.
module instr_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
`ifdef INSTR_PREFETCH_FLUSH_CNT_EN
    ,
    output logic [31:0] flush_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW:0]   SLOTS   = (CW + 1)'(DEPTH);

    // FETCH: requesting; FULL: every slot is claimed by the FIFO or an
    // in-flight request; HOLD: a redirect arrived while a request was still
    // waiting for its grant, so the old request is finished first.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_FULL  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]   fpc;
    logic [31:0]   hold_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] out_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] cnt_nxt;
    logic [CW:0]   sum_nxt;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rq_wr;
    logic [AW-1:0] rq_rd;

    logic [31:0] fifo_data [DEPTH];
    logic [31:0] fifo_pc   [DEPTH];
    logic [31:0] req_pc    [DEPTH];

    logic gnt_fire;
    logic rsp_drop;
    logic push;
    logic pop;

    assign gnt_fire = mem_req & mem_gnt;
    assign rsp_drop = mem_rvalid & (drop_cnt != '0);
    assign pop      = instr_valid & instr_ready & ~redirect_valid;
    assign push     = mem_rvalid & ~rsp_drop & ~redirect_valid &
                      ((fifo_count != CW'(DEPTH)) | pop);

    assign instr_valid = (fifo_count != '0);
    assign instr_data  = instr_valid ? fifo_data[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : 32'h0;
    assign mem_addr    = fpc;

    assign out_nxt = outstanding + CW'(gnt_fire) - CW'(mem_rvalid);
    assign cnt_nxt = redirect_valid ? '0 : (fifo_count + CW'(push) - CW'(pop));
    assign sum_nxt = {1'b0, out_nxt} + {1'b0, cnt_nxt};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and request generation; FETCH is only ever occupied
    // while at least one slot is free, so mem_req follows the state directly.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req = ~rst;
                if (redirect_valid && !mem_gnt) begin
                    state_nxt = ST_HOLD;
                end else if (sum_nxt >= SLOTS) begin
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (sum_nxt < SLOTS) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_HOLD: begin
                mem_req = ~rst;
                if (mem_gnt) begin
                    state_nxt = (sum_nxt >= SLOTS) ? ST_FULL : ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

    // Fetch pointer; a redirect during an ungranted request parks the target
    // in hold_pc so the bus address stays stable until the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc     <= RESET_PC;
            hold_pc <= RESET_PC;
        end else if (redirect_valid && mem_req && !mem_gnt) begin
            hold_pc <= redirect_pc;
        end else if (redirect_valid) begin
            fpc <= redirect_pc;
        end else if (state == ST_HOLD && mem_gnt) begin
            fpc <= hold_pc;
        end else if (gnt_fire) begin
            fpc <= fpc + 32'd4;
        end
    end

    // In-flight and drop accounting; a live request at redirect time (granted
    // now or in HOLD later) is stale and is counted as a drop as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= out_nxt;
            if (redirect_valid) begin
                drop_cnt <= outstanding - CW'(mem_rvalid) + CW'(mem_req);
            end else if (rsp_drop) begin
                drop_cnt <= drop_cnt - CNT_ONE;
            end
        end
    end

    // Pointers for the request-address queue and the instruction FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq_wr      <= '0;
            rq_rd      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (gnt_fire) begin
                rq_wr <= rq_wr + PTR_ONE;
            end
            if (mem_rvalid) begin
                rq_rd <= rq_rd + PTR_ONE;
            end
            fifo_count <= cnt_nxt;
            if (redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
        end
    end

    // Storage: request addresses on grant, {data, pc} pairs on accepted response.
    always_ff @(posedge clk) begin
        if (gnt_fire) begin
            req_pc[rq_wr] <= fpc;
        end
        if (push) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_pc[wr_ptr]   <= req_pc[rq_rd];
        end
    end

`ifdef INSTR_PREFETCH_FLUSH_CNT_EN
    // Saturating count of redirect cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= 32'h0;
        end else if (redirect_valid && flush_cnt != 32'hFFFF_FFFF) begin
            flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: a per-cycle vector table for the steady-state
// and back-pressure behaviour, then hand sequences for redirect, drop,
// wrap-around and mid-burst reset. The bus model grants when told to and
// returns addr ^ 32'hA5A5_0000 one cycle after each grant, in order.
module tb_instr_prefetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef INSTR_PREFETCH_FLUSH_CNT_EN
    logic [31:0] flush_cnt;
`endif

    instr_prefetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
`ifdef INSTR_PREFETCH_FLUSH_CNT_EN
        ,
        .flush_cnt      (flush_cnt)
`endif
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    int          gnt_cnt;
    logic        sb_en;
    logic        rsp_stall;
    logic [31:0] rsp_q[$];
    logic [31:0] exp_q[$];

    typedef struct {
        logic        gnt;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sample pre-edge, clock once, then update the bus model after the edge.
    task automatic advance();
        logic        g;
        logic [31:0] ga;
        logic [31:0] e;
        g  = mem_req && mem_gnt;
        ga = mem_addr;
        if (g) gnt_cnt++;
        if (sb_en && instr_valid && instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_pc", instr_pc, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", instr_pc, e);
                chk("sb_data", instr_data, e ^ KEY);
            end
        end
        @(posedge clk);
        #1;
        if (g) rsp_q.push_back(ga);
        if (!rsp_stall && rsp_q.size() > 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rsp_q.pop_front() ^ KEY;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
    endtask

    task automatic tick();
        #2;
        advance();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_gnt        = 1'b0;
        instr_ready    = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = 32'h0;
        sb_en          = 1'b0;
        rsp_stall      = 1'b0;
        rsp_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'h0);
    endtask

    // Leaves time at the settled pre-edge point of a cycle with mem_req high.
    task automatic wait_req(input string name, input int budget);
        int n;
        n = 0;
        #2;
        while (!mem_req && n < budget) begin
            advance();
            #2;
            n++;
        end
        chk(name, {31'h0, mem_req}, 32'h1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        gnt_cnt = 0;
        sb_en = 1'b0;
        rsp_stall = 1'b0;

        vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h08};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 32'h08};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h08};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};

        // Reset values.
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        mem_gnt = 1'b0;
        instr_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr_data", instr_data, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
`ifdef INSTR_PREFETCH_FLUSH_CNT_EN
        chk("rst_flush_cnt", flush_cnt, 32'h0);
`endif

        // Cycle-by-cycle table: streaming, back-pressure into FULL, release.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            mem_gnt     = vecs[i].gnt;
            instr_ready = vecs[i].rdy;
            #2;
            chk($sformatf("vec%0d_req", i), {31'h0, mem_req}, {31'h0, vecs[i].req});
            if (vecs[i].req) chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
            chk($sformatf("vec%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].vld});
            if (vecs[i].vld) begin
                chk($sformatf("vec%0d_pc", i), instr_pc, vecs[i].pc);
                chk($sformatf("vec%0d_data", i), instr_data, vecs[i].pc ^ KEY);
            end
            advance();
        end

        // Back-pressure: exactly DEPTH grants, then one more per freed slot.
        do_reset();
        mem_gnt = 1'b1;
        gnt_cnt = 0;
        repeat (10) tick();
        chk("full_grants", 32'(gnt_cnt), 32'd4);
        chk("full_req_low", {31'h0, mem_req}, 32'h0);
        gnt_cnt = 0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        repeat (8) tick();
        chk("one_more_grant", 32'(gnt_cnt), 32'd1);
        chk("refull_req_low", {31'h0, mem_req}, 32'h0);

        // Redirect while a request waits for its grant.
        do_reset();
        mem_gnt = 1'b1;
        instr_ready = 1'b1;
        sb_en = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        tick();
        tick();
        mem_gnt = 1'b0;
        #2;
        chk("hold_req_c1", {31'h0, mem_req}, 32'h1);
        chk("hold_addr_c1", mem_addr, 32'h8);
        advance();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #2;
        chk("hold_addr_c2", mem_addr, 32'h8);
        advance();
        redirect_valid = 1'b0;
        #2;
        chk("hold_req_c3", {31'h0, mem_req}, 32'h1);
        chk("hold_addr_c3", mem_addr, 32'h8);
        advance();
        mem_gnt = 1'b1;
        #2;
        chk("hold_addr_gnt", mem_addr, 32'h8);
        advance();
        #2;
        chk("hold_next_addr", mem_addr, 32'h100);
        advance();
        wait_empty("hold_stream_done", 30);

        // Redirect with three responses in flight plus a same-cycle grant.
        do_reset();
        mem_gnt = 1'b1;
        instr_ready = 1'b1;
        rsp_stall = 1'b1;
        sb_en = 1'b1;
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        exp_q.push_back(32'h48);
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("drop_full_req", {31'h0, mem_req}, 32'h0);
        chk("drop_valid_low", {31'h0, instr_valid}, 32'h0);
        rsp_stall = 1'b0;
        wait_empty("drop_stream_done", 40);

        // Full FIFO drains in order while refilling; then fpc wrap-around.
        do_reset();
        mem_gnt = 1'b1;
        repeat (8) tick();
        chk("fill_valid", {31'h0, instr_valid}, 32'h1);
        chk("fill_head_pc", instr_pc, 32'h0);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        sb_en = 1'b1;
        instr_ready = 1'b1;
        wait_empty("order_stream_done", 40);
        instr_ready = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        wait_req("wrap_req", 20);
        chk("wrap_addr_top", mem_addr, 32'hFFFF_FFFC);
        advance();
        #2;
        chk("wrap_addr_zero", mem_addr, 32'h0);
        advance();
        instr_ready = 1'b1;
        wait_empty("wrap_stream_done", 40);

        // Redirect burst, then reset asserted in the middle of a cycle.
        do_reset();
        mem_gnt = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            redirect_valid = 1'b1;
            redirect_pc = 32'h200 + 32'(i * 16);
            tick();
            redirect_valid = 1'b0;
            tick();
        end
`ifdef INSTR_PREFETCH_FLUSH_CNT_EN
        chk("flush_cnt_5", flush_cnt, 32'd5);
`endif
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_req", {31'h0, mem_req}, 32'h0);
        chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
        chk("midrst_data", instr_data, 32'h0);
        chk("midrst_pc", instr_pc, 32'h0);
`ifdef INSTR_PREFETCH_FLUSH_CNT_EN
        chk("midrst_flush_cnt", flush_cnt, 32'h0);
`endif
        rsp_q.delete();
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_en = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        #2;
        chk("post_rst_req", {31'h0, mem_req}, 32'h1);
        chk("post_rst_addr", mem_addr, 32'h0);
        advance();
        wait_empty("post_rst_stream_done", 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, meaning instruction FIFO entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 redirect_valid  input  1  flush the buffer and restart fetching at redirect_pc.
REQ-007 redirect_pc  input  32  new fetch address, word aligned.
REQ-008 instr_valid  output  1  instr_data and instr_pc hold a valid instruction.
REQ-009 instr_data  output  32  instruction at the FIFO head.
REQ-010 instr_pc  output  32  address of instr_data.
REQ-011 instr_ready  input  1  decode consumes the head entry when instr_valid is also high.
REQ-012 mem_req  output  1  instruction-bus read request.
REQ-013 mem_addr  output  32  request address.
REQ-014 mem_gnt  input  1  request accepted this cycle.
REQ-015 mem_rvalid  input  1  read data returned, in request order, at least 1 cycle after grant.
REQ-016 mem_rdata  input  32  returned instruction word.

Function
REQ-017 Fetch pointer fpc: it SHALL advance by 4 on each cycle in which mem_req and mem_gnt are both high, wrapping modulo 2^32.
REQ-018 mem_addr SHALL equal fpc, and while mem_req is high without a grant, mem_req and mem_addr SHALL stay stable.
REQ-019 The FSM SHALL have three states:
- FETCH: mem_req high when outstanding plus fifo_count is less than DEPTH.
- FULL: mem_req low; entered when outstanding plus fifo_count equals DEPTH; returns to FETCH once a slot frees.
- HOLD: a redirect arrived while a request was pending and ungranted; mem_req stays high at the old address until the grant, then the FSM goes to FETCH at the redirect address.
REQ-020 The outstanding counter SHALL increment on a grant and decrement on mem_rvalid; if both occur in the same cycle it is unchanged. Its width is clog2(DEPTH)+1.
REQ-021 Each returned response SHALL be written to the FIFO tail as {mem_rdata, pc of the matching request}, unless it is marked as a drop.
REQ-022 Handshake: the head entry SHALL pop only on instr_valid & instr_ready. instr_data/instr_pc SHALL remain stable while instr_valid is high and instr_ready is low.
REQ-023 Latency: rvalid in cycle N SHALL give instr_valid in cycle N+1. There is no bypass path.
REQ-024 Push and pop in the same cycle on a full FIFO SHALL both succeed, and the count is unchanged.
REQ-025 On redirect_valid:
- the FIFO SHALL empty in the next cycle, and any same-cycle pop or push is discarded;
- the drop counter SHALL be loaded with the number of responses still in flight, where in-flight means outstanding, minus a same-cycle rvalid, plus a same-cycle or HOLD grant;
- fpc SHALL load redirect_pc.
REQ-026 While the drop counter is nonzero, every mem_rvalid SHALL decrement it and SHALL NOT be written to the FIFO.
REQ-027 The FIFO pointers SHALL wrap modulo DEPTH. instr_valid SHALL be low when the FIFO is empty.
REQ-028 A second redirect that arrives while drops are pending SHALL recompute the drop count per REQ-025. The last redirect wins.

Reset
REQ-029 While rst is high:
- mem_req=0, instr_valid=0, instr_data=0, instr_pc=0;
- the FIFO is empty and the outstanding and drop counters are 0;
- FSM=FETCH and fpc=RESET_PC.
REQ-030 Reset asserted mid-transaction SHALL abandon all in-flight requests. The external bus is reset by the same rst.
REQ-031 The first mem_req SHALL assert in the first cycle after rst deasserts.

Configuration
REQ-032 With macro INSTR_PREFETCH_FLUSH_CNT_EN defined, output flush_cnt [31:0] SHALL exist:
- it increments on each redirect_valid cycle;
- it saturates at 32'hFFFF_FFFF;
- it resets to 0.
REQ-033 Without INSTR_PREFETCH_FLUSH_CNT_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Reset, then mem_gnt=1 every cycle and rvalid 1 cycle after the grant with rdata=addr^32'hA5A5_0000, instr_ready=1 -> mem_addr sequence 0,4,8,...; the first instr_valid has instr_pc=0 and data 32'hA5A5_0000.
REQ-035 Hold instr_ready=0 with DEPTH=4 -> exactly 4 grants, then mem_req=0 (FULL). Raising instr_ready for one cycle -> exactly one further request is issued.
REQ-036 Hold mem_gnt=0 for 3 cycles at addr 8, with redirect_valid (redirect_pc=0x100) in the 2nd of those cycles -> mem_addr stays 8 until the grant; the next request is 0x100; the response for 8 is dropped; the first instr_pc is 0x100.
REQ-037 With 3 requests outstanding, redirect to 0x40 -> the 3 old responses are discarded; the next instr_pc is 0x40; instr_valid stays low in between.
REQ-038 With a full FIFO and instr_ready=1, push and pop in the same cycle -> the count stays at DEPTH and order is preserved. Also start at fpc=0xFFFF_FFFC -> the next mem_addr is 0x0000_0000.
REQ-039 With INSTR_PREFETCH_FLUSH_CNT_EN defined, 5 redirects -> flush_cnt=5; asserting rst mid-burst -> flush_cnt=0, mem_req=0 and instr_valid=0 immediately.
